// File: rtl/tpg_multi.sv
// Two-stage pipelined VGA test-pattern generator with eight frame-locked modes.
// Stage 1 resolves mode/scroll per pixel; stage 2 turns that into the colour.
module tpg_multi #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int CNT_W       = 10,
   parameter int R_W         = 3,
   parameter int G_W         = 3,
   parameter int B_W         = 2,
   parameter int GRID_LOG2   = 5,
   parameter int CHK_LOG2    = 4,
   parameter int CELL_W      = 8,
   parameter int CELL_H      = 16,
   parameter int SCROLL_STEP = 2
) (
   input  logic                   clk_pix,
   input  logic                   resetn,
   input  logic [CNT_W-1:0]       hcount,
   input  logic [CNT_W-1:0]       vcount,
   input  logic                   de,
   input  logic                   hsync,
   input  logic                   vsync,
   input  logic [2:0]             mode,
   input  logic [R_W+G_W+B_W-1:0] solid_rgb,
   input  logic                   freeze,
   output logic [R_W-1:0]         rgb_r,
   output logic [G_W-1:0]         rgb_g,
   output logic [B_W-1:0]         rgb_b,
   output logic                   de_o,
   output logic                   hsync_o,
   output logic                   vsync_o,
   output logic [7:0]             frame_cnt
);

   localparam int RGB_W   = R_W + G_W + B_W;
   localparam int BAR_PX  = H_ACTIVE / 8;
   localparam int CELL_XB = $clog2(CELL_W);
   localparam int CELL_YB = $clog2(CELL_H);
   localparam logic [CNT_W:0] H_EXT    = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0] STEP_EXT = (CNT_W+1)'(SCROLL_STEP);

   logic             fs;
   logic [2:0]       mode_eff;
   logic [2:0]       mode_q;
   logic [CNT_W-1:0] offset;
   logic [CNT_W-1:0] offset_act;
   logic [CNT_W-1:0] off_eff;
   logic [CNT_W-1:0] off_nxt;
   logic [CNT_W-1:0] x_scr;
   logic [CNT_W-1:0] x_bar;
   logic [CNT_W:0]   x_sum;
   logic [CNT_W:0]   off_sum;

   logic             de1;
   logic             hs1;
   logic             vs1;
   logic [2:0]       mode1;
   logic [CNT_W-1:0] x1;
   logic [CNT_W-1:0] y1;
   logic [CNT_W-1:0] xb1;
   logic [RGB_W-1:0] solid1;

   logic [CNT_W-1:0] bar_idx;
   logic [2:0]       bar_c;
   logic [2:0]       tri_c;
   logic             use_tri;
   logic             grid_hit;
   logic             chk_hit;
   logic             cell_x;
   logic             cell_y;
   logic [R_W-1:0]   r_n;
   logic [G_W-1:0]   g_n;
   logic [B_W-1:0]   b_n;

   function automatic int grad_level(input logic [CNT_W-1:0] x, input int w);
      int lvl;
      lvl = (int'(x) << w) / H_ACTIVE;
      if (lvl > (1 << w) - 1)
         lvl = (1 << w) - 1;
      return lvl;
   endfunction

   // The frame-start pixel already uses the newly selected mode, while the
   // scroll offset advanced at a frame start only takes effect one frame later.
   always_comb begin
      fs       = de && (hcount == '0) && (vcount == '0);
      mode_eff = fs ? mode : mode_q;
      off_eff  = fs ? offset : offset_act;
      x_sum    = {1'b0, hcount} + {1'b0, off_eff};
      x_scr    = (x_sum >= H_EXT) ? CNT_W'(x_sum - H_EXT) : x_sum[CNT_W-1:0];
      x_bar    = (mode_eff == 3'd5) ? x_scr : hcount;
      off_sum  = {1'b0, offset} + STEP_EXT;
      off_nxt  = (off_sum >= H_EXT) ? CNT_W'(off_sum - H_EXT) : off_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk_pix) begin
      if (!resetn) begin
         mode_q     <= '0;
         offset     <= '0;
         offset_act <= '0;
         frame_cnt  <= '0;
         de1        <= 1'b0;
         hs1        <= 1'b0;
         vs1        <= 1'b0;
         mode1      <= '0;
         x1         <= '0;
         y1         <= '0;
         xb1        <= '0;
         solid1     <= '0;
      end else begin
         de1    <= de;
         hs1    <= hsync;
         vs1    <= vsync;
         mode1  <= mode_eff;
         x1     <= hcount;
         y1     <= vcount;
         xb1    <= x_bar;
         solid1 <= solid_rgb;
         if (fs) begin
            mode_q     <= mode;
            frame_cnt  <= frame_cnt + 8'd1;
            offset_act <= offset;
            if (!freeze)
               offset <= off_nxt;
         end
      end
   end

   // Most modes reduce to a one-bit-per-channel triple that is widened at the end.
   always_comb begin
      bar_idx  = xb1 / CNT_W'(BAR_PX);
      bar_c    = (bar_idx > CNT_W'(7)) ? 3'd0 : 3'd7 - bar_idx[2:0];
      grid_hit = (x1[GRID_LOG2-1:0] == '0) || (y1[GRID_LOG2-1:0] == '0) ||
                 (x1 == CNT_W'(H_ACTIVE-1)) || (y1 == CNT_W'(V_ACTIVE-1));
      chk_hit  = x1[CHK_LOG2] ^ y1[CHK_LOG2];
      cell_x   = (x1[CELL_XB-1:0] == '0);
      cell_y   = (y1[CELL_YB-1:0] == '0);
      tri_c    = 3'b000;
      use_tri  = 1'b1;
      r_n      = '0;
      g_n      = '0;
      b_n      = '0;
      case (mode1)
         3'd0, 3'd5: tri_c = bar_c;
         3'd1:       tri_c = grid_hit ? 3'b111 : 3'b000;
         3'd2:       tri_c = chk_hit ? 3'b111 : 3'b000;
         3'd3:       tri_c = (cell_x && cell_y) ? 3'b010 :
                             (cell_x || cell_y) ? 3'b001 : 3'b000;
         3'd4: begin
            use_tri = 1'b0;
            r_n     = R_W'(grad_level(x1, R_W));
            g_n     = G_W'(grad_level(x1, G_W));
            b_n     = B_W'(grad_level(x1, B_W));
         end
         3'd6: begin
            use_tri         = 1'b0;
            {r_n, g_n, b_n} = solid1;
         end
         default:    tri_c = 3'b000;
      endcase
      if (use_tri) begin
         r_n = {R_W{tri_c[2]}};
         g_n = {G_W{tri_c[1]}};
         b_n = {B_W{tri_c[0]}};
      end
      if (!de1) begin
         r_n = '0;
         g_n = '0;
         b_n = '0;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (!resetn) begin
         rgb_r   <= '0;
         rgb_g   <= '0;
         rgb_b   <= '0;
         de_o    <= 1'b0;
         hsync_o <= 1'b0;
         vsync_o <= 1'b0;
      end else begin
         rgb_r   <= r_n;
         rgb_g   <= g_n;
         rgb_b   <= b_n;
         de_o    <= de1;
         hsync_o <= hs1;
         vsync_o <= vs1;
      end
   end

endmodule

// File: tb/tb_tpg_multi.sv
// Self-checking bench for tpg_multi: fixed vector table, directed frame
// sequences and random pixels, all compared against a behavioural model.
module tb_tpg_multi;

   localparam int H    = 640;
   localparam int V    = 480;
   localparam int STEP = 2;

   logic       clk_pix = 1'b0;
   logic       resetn;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic       de;
   logic       hsync;
   logic       vsync;
   logic [2:0] mode;
   logic [7:0] solid_rgb;
   logic       freeze;
   logic [2:0] rgb_r;
   logic [2:0] rgb_g;
   logic [1:0] rgb_b;
   logic       de_o;
   logic       hsync_o;
   logic       vsync_o;
   logic [7:0] frame_cnt;

   tpg_multi dut (
      .clk_pix(clk_pix), .resetn(resetn), .hcount(hcount), .vcount(vcount),
      .de(de), .hsync(hsync), .vsync(vsync), .mode(mode), .solid_rgb(solid_rgb),
      .freeze(freeze), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .de_o(de_o),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_cnt(frame_cnt)
   );

   always #5 clk_pix = ~clk_pix;

   typedef struct {
      logic       de;
      int         x;
      int         y;
      logic       hs;
      logic       vs;
      logic [2:0] mode;
      logic [7:0] solid;
      logic       freeze;
   } stim_t;

   typedef struct {
      logic [2:0] mode;
      int         x;
      int         y;
      logic       de;
      logic [7:0] solid;
      logic [7:0] expRgb;
   } vec_t;

   int          nVectors = 0;
   int          nMiscompares = 0;
   int          mMode, mAcc, mFrameOff, mFcnt;
   logic [10:0] expPrev;
   logic        gFreeze = 1'b0;
   vec_t        vecs[$];

   // Colour of one active pixel straight from the pattern definitions.
   function automatic logic [7:0] refPixel(int md, int x, int y, int off, logic [7:0] solid);
      int c, xs, b, r, g, bl;
      c = 0;
      case (md)
         0, 5: begin
            xs = x;
            if (md == 5) begin
               xs = x + off;
               if (xs >= H) xs = xs - H;
            end
            b = xs / (H / 8);
            if (b > 7) b = 7;
            c = 7 - b;
         end
         1: c = (x % 32 == 0 || y % 32 == 0 || x == H - 1 || y == V - 1) ? 7 : 0;
         2: c = (((x / 16) + (y / 16)) % 2 == 1) ? 7 : 0;
         3: c = (x % 8 == 0 && y % 16 == 0) ? 2 : ((x % 8 == 0 || y % 16 == 0) ? 1 : 0);
         4: begin
            r  = (x * 8) / H;  if (r > 7) r = 7;
            g  = (x * 8) / H;  if (g > 7) g = 7;
            bl = (x * 4) / H;  if (bl > 3) bl = 3;
            return {r[2:0], g[2:0], bl[1:0]};
         end
         6: return solid;
         default: c = 0;
      endcase
      return {{3{c[2]}}, {3{c[1]}}, {2{c[0]}}};
   endfunction

   function automatic stim_t pix(logic d, int x, int y, logic [2:0] md, logic [7:0] solid);
      stim_t s;
      s.de = d; s.x = x; s.y = y; s.hs = 1'b0; s.vs = 1'b0;
      s.mode = md; s.solid = solid; s.freeze = gFreeze;
      return s;
   endfunction

   function automatic logic [31:0] outBus();
      return 32'({rgb_r, rgb_g, rgb_b, de_o, hsync_o, vsync_o});
   endfunction

   function automatic logic [31:0] rgbNow();
      return 32'({rgb_r, rgb_g, rgb_b});
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
      nVectors++;
      if (got !== expv) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, expv, $time);
      end
   endtask

   // Drives one pixel, advances the frame model, and checks the pixel two back.
   task automatic applyStimulus(input stim_t s);
      logic [7:0]  px;
      logic [10:0] expCur;
      if (s.de && s.x == 0 && s.y == 0) begin
         mFrameOff = mAcc;
         if (!s.freeze) begin
            mAcc = mAcc + STEP;
            if (mAcc >= H) mAcc = mAcc - H;
         end
         mFcnt = (mFcnt + 1) % 256;
         mMode = int'(s.mode);
      end
      px     = s.de ? refPixel(mMode, s.x, s.y, mFrameOff, s.solid) : 8'h00;
      expCur = {px, s.de, s.hs, s.vs};
      de = s.de; hcount = 10'(s.x); vcount = 10'(s.y); hsync = s.hs; vsync = s.vs;
      mode = s.mode; solid_rgb = s.solid; freeze = s.freeze;
      @(posedge clk_pix); #1;
      checkOutput("pipe_out", outBus(), 32'(expPrev));
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(mFcnt));
      expPrev = expCur;
   endtask

   task automatic idle();
      applyStimulus(pix(1'b0, 5, 5, 3'd0, 8'h00));
   endtask

   task automatic doReset(input int n);
      resetn = 1'b0; de = 1'b1; hcount = '0; vcount = '0; hsync = 1'b1; vsync = 1'b1;
      mode = 3'd2; solid_rgb = 8'hFF; freeze = 1'b0;
      repeat (n) begin
         @(posedge clk_pix); #1;
         checkOutput("rst_out", outBus(), 32'h0);
         checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'h0);
      end
      resetn = 1'b1;
      mMode = 0; mAcc = 0; mFrameOff = 0; mFcnt = 0; expPrev = '0;
   endtask

   initial begin
      stim_t s;

      // Reset, then the first frame start locks the checker mode.
      doReset(3);
      applyStimulus(pix(1'b1, 0, 0, 3'd2, 8'h00));
      applyStimulus(pix(1'b1, 16, 0, 3'd2, 8'h00));
      checkOutput("rst_chk_00", rgbNow(), 32'h00);
      checkOutput("rst_fc1", 32'(frame_cnt), 32'd1);
      idle();
      checkOutput("rst_chk_16", rgbNow(), 32'hFF);

      // Two-cycle alignment of colour, de and hsync.
      applyStimulus(pix(1'b1, 0, 0, 3'd0, 8'h00));
      idle();
      idle();
      s = pix(1'b1, 0, 10, 3'd0, 8'h00);
      s.hs = 1'b1;
      applyStimulus(s);
      checkOutput("lat_early", 32'({de_o, hsync_o}), 32'h0);
      idle();
      checkOutput("lat_rgb", rgbNow(), 32'hFF);
      checkOutput("lat_de_hs", 32'({de_o, hsync_o}), 32'h3);
      idle();
      checkOutput("lat_after", 32'({de_o, hsync_o}), 32'h0);

      // A mode change mid-frame waits for the next frame start.
      applyStimulus(pix(1'b1, 0, 0, 3'd0, 8'h00));
      applyStimulus(pix(1'b1, 80, 100, 3'd1, 8'h00));
      idle();
      checkOutput("lock_bars", rgbNow(), 32'hFC);
      applyStimulus(pix(1'b1, 0, 0, 3'd1, 8'h00));
      applyStimulus(pix(1'b1, 32, 1, 3'd1, 8'h00));
      applyStimulus(pix(1'b1, 33, 1, 3'd1, 8'h00));
      checkOutput("lock_grid32", rgbNow(), 32'hFF);
      idle();
      checkOutput("lock_grid33", rgbNow(), 32'h00);

      // Table of single pixels, each preceded by a frame start with its mode.
      vecs.push_back('{3'd0, 0,   5,   1'b1, 8'h00, 8'hFF});
      vecs.push_back('{3'd0, 80,  5,   1'b1, 8'h00, 8'hFC});
      vecs.push_back('{3'd0, 160, 5,   1'b1, 8'h00, 8'hE3});
      vecs.push_back('{3'd0, 240, 5,   1'b1, 8'h00, 8'hE0});
      vecs.push_back('{3'd0, 320, 5,   1'b1, 8'h00, 8'h1F});
      vecs.push_back('{3'd0, 400, 5,   1'b1, 8'h00, 8'h1C});
      vecs.push_back('{3'd0, 559, 5,   1'b1, 8'h00, 8'h03});
      vecs.push_back('{3'd0, 639, 5,   1'b1, 8'h00, 8'h00});
      vecs.push_back('{3'd1, 639, 7,   1'b1, 8'h00, 8'hFF});
      vecs.push_back('{3'd1, 5,   479, 1'b1, 8'h00, 8'hFF});
      vecs.push_back('{3'd1, 5,   64,  1'b1, 8'h00, 8'hFF});
      vecs.push_back('{3'd1, 5,   63,  1'b1, 8'h00, 8'h00});
      vecs.push_back('{3'd2, 16,  0,   1'b1, 8'h00, 8'hFF});
      vecs.push_back('{3'd2, 16,  16,  1'b1, 8'h00, 8'h00});
      vecs.push_back('{3'd2, 3,   3,   1'b1, 8'h00, 8'h00});
      vecs.push_back('{3'd3, 0,   0,   1'b1, 8'h00, 8'h1C});
      vecs.push_back('{3'd3, 8,   5,   1'b1, 8'h00, 8'h03});
      vecs.push_back('{3'd3, 3,   3,   1'b1, 8'h00, 8'h00});
      vecs.push_back('{3'd3, 8,   16,  1'b1, 8'h00, 8'h1C});
      vecs.push_back('{3'd3, 3,   16,  1'b1, 8'h00, 8'h03});
      vecs.push_back('{3'd4, 0,   9,   1'b1, 8'h00, 8'h00});
      vecs.push_back('{3'd4, 79,  9,   1'b1, 8'h00, 8'h00});
      vecs.push_back('{3'd4, 80,  9,   1'b1, 8'h00, 8'h24});
      vecs.push_back('{3'd4, 160, 9,   1'b1, 8'h00, 8'h49});
      vecs.push_back('{3'd4, 320, 9,   1'b1, 8'h00, 8'h92});
      vecs.push_back('{3'd4, 639, 9,   1'b1, 8'h00, 8'hFF});
      vecs.push_back('{3'd6, 10,  9,   1'b1, 8'hAB, 8'hAB});
      vecs.push_back('{3'd6, 10,  9,   1'b0, 8'hAB, 8'h00});
      vecs.push_back('{3'd7, 10,  9,   1'b1, 8'hFF, 8'h00});
      vecs.push_back('{3'd2, 16,  0,   1'b0, 8'h00, 8'h00});
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(pix(1'b1, 0, 0, vecs[i].mode, vecs[i].solid));
         applyStimulus(pix(vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].mode, vecs[i].solid));
         idle();
         checkOutput($sformatf("vec%0d", i), rgbNow(), 32'(vecs[i].expRgb));
      end

      // Reset mid-frame falls back to bars until the next frame start.
      applyStimulus(pix(1'b1, 0, 0, 3'd3, 8'h00));
      doReset(1);
      applyStimulus(pix(1'b1, 8, 5, 3'd3, 8'h00));
      idle();
      checkOutput("rst_mode0", rgbNow(), 32'hFF);

      // Scrolling bars over a full wrap of the offset.
      doReset(1);
      for (int k = 1; k <= 321; k++) begin
         applyStimulus(pix(1'b1, 0, 0, 3'd5, 8'h00));
         applyStimulus(pix(1'b1, 639, 1, 3'd5, 8'h00));
         if (k == 41)  checkOutput("scroll_off80", rgbNow(), 32'hFC);
         if (k == 320) checkOutput("scroll_off638", rgbNow(), 32'h00);
         if (k == 321) checkOutput("scroll_wrap", rgbNow(), 32'hFF);
         idle();
      end
      checkOutput("scroll_fc", 32'(frame_cnt), 32'd65);

      // Freeze holds the offset while frame_cnt keeps counting.
      doReset(1);
      applyStimulus(pix(1'b1, 0, 0, 3'd5, 8'h00));
      idle();
      gFreeze = 1'b1;
      for (int f = 2; f <= 4; f++) begin
         applyStimulus(pix(1'b1, 0, 0, 3'd5, 8'h00));
         applyStimulus(pix(1'b1, 77, 3, 3'd5, 8'h00));
         idle();
         checkOutput($sformatf("frz_px%0d", f), rgbNow(), 32'hFF);
      end
      checkOutput("frz_fc", 32'(frame_cnt), 32'd4);
      gFreeze = 1'b0;
      for (int f = 5; f <= 6; f++) begin
         applyStimulus(pix(1'b1, 0, 0, 3'd5, 8'h00));
         applyStimulus(pix(1'b1, 77, 3, 3'd5, 8'h00));
         idle();
      end
      checkOutput("unfrz_px", rgbNow(), 32'hFC);

      // Random pixels with occasional frame starts against the model.
      for (int n = 0; n < 3000; n++) begin
         s.de = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            s.de = 1'b1; s.x = 0; s.y = 0;
         end else begin
            s.x = int'($urandom_range(0, H - 1));
            s.y = int'($urandom_range(0, V - 1));
         end
         s.hs     = 1'($urandom_range(0, 1));
         s.vs     = 1'($urandom_range(0, 1));
         s.mode   = 3'($urandom_range(0, 7));
         s.solid  = 8'($urandom);
         s.freeze = ($urandom_range(0, 3) == 0);
         applyStimulus(s);
      end
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/tpg_multi.md
Name: tpg_multi

Overview:
Parametrised, pipelined test-pattern generator for the VGA output path. It is driven by the hcount/vcount/de/sync signals from vga_timing, and feeds the DAC/pin stage.
- Supports eight frame-locked modes, including an animated scrolling mode.
- Channel widths are configurable.
- Sync and de are delayed so they stay aligned with the pixel data.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
CNT_W, 10, hcount/vcount width
R_W, 3, red channel width
G_W, 3, green channel width
B_W, 2, blue channel width
GRID_LOG2, 5, grid pitch = 2^GRID_LOG2 pixels
CHK_LOG2, 4, checker square = 2^CHK_LOG2 pixels
CELL_W, 8, char-cell width (power of 2)
CELL_H, 16, char-cell height (power of 2)
SCROLL_STEP, 2, pixels advanced per frame in mode 5 (must be < H_ACTIVE)

Ports:
clk_pix  in  1  pixel clock
resetn  in  1  synchronous, active-low reset
hcount  in  CNT_W  pixel x from vga_timing
vcount  in  CNT_W  line y from vga_timing
de  in  1  active-area enable
hsync  in  1  horizontal sync (polarity passed through)
vsync  in  1  vertical sync (polarity passed through)
mode  in  3  pattern select
solid_rgb  in  R_W+G_W+B_W  {R,G,B} colour for mode 6
freeze  in  1  hold scroll offset
rgb_r  out  R_W  red
rgb_g  out  G_W  green
rgb_b  out  B_W  blue
de_o  out  1  de delayed 2 cycles
hsync_o  out  1  hsync delayed 2 cycles
vsync_o  out  1  vsync delayed 2 cycles
frame_cnt  out  8  frames started since reset, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk_pix. Reset is synchronous and active-low on resetn.
- Reset values (resetn low at a clk_pix edge):
  - rgb_*, de_o, hsync_o, vsync_o, frame_cnt = 0
  - internal mode_q = 0, scroll offset = 0, pipeline registers = 0
  - Deasserting resetn mid-frame resumes with mode_q=0 until the next frame start.
- Latency: fixed at 2 cycles. Stage 1 registers the inputs and pattern intermediates; stage 2 registers the colour. rgb/de_o/sync_o all reflect the input sampled 2 edges earlier.
- Frame start (fs): de=1 && hcount==0 && vcount==0. On fs:
  - mode_q <= mode
  - frame_cnt <= frame_cnt+1
  - if freeze=0, offset <= (offset+SCROLL_STEP), minus H_ACTIVE if >= H_ACTIVE
  - The new mode applies from that same pixel. The new offset applies from the following frame.
  - Mode changes mid-frame are ignored until the next fs.
- Colour rules:
  - "Full" = all ones in the channel width.
  - Colour triple c={R,G,B} means each channel is full (1) or 0.
  - de=0 at stage input forces output 0 two cycles later.
- Modes, applied for de=1 pixel (x=hcount, y=vcount):
  - 0 colour bars: b = x / (H_ACTIVE/8), clamped to 7; c = 7-b. Left to right: white, yellow, magenta, red, cyan, green, blue, black.
  - 1 grid: white if x[GRID_LOG2-1:0]==0, or y[GRID_LOG2-1:0]==0, or x==H_ACTIVE-1, or y==V_ACTIVE-1; else black.
  - 2 checker: white if x[CHK_LOG2] ^ y[CHK_LOG2]; else black.
  - 3 char-cell markers: green (0,full,0) at x%CELL_W==0 && y%CELL_H==0; blue at other pixels with x%CELL_W==0 or y%CELL_H==0; else black.
  - 4 gradient: each channel = top bits of x scaled to H_ACTIVE, i.e. chan = (x * 2^W) / H_ACTIVE, saturating at full.
  - 5 scrolling bars: mode 0 evaluated at x' = x+offset, minus H_ACTIVE if >= H_ACTIVE.
  - 6 solid: solid_rgb, sampled every pixel, not frame-locked.
  - 7 reserved: black.
- Boundaries:
  - The x==H_ACTIVE-1 bar is bar 7.
  - Offset never reaches H_ACTIVE.
  - frame_cnt wraps silently.
  - fs during freeze still increments frame_cnt.

Test Plan:
1. Reset: hold resetn=0 3 cycles with de=1 -> all outputs 0, frame_cnt=0. First fs after release with mode=2 -> checker from pixel (0,0).
2. Latency/alignment: mode 0, pulse de high at hcount=0 -> rgb = (7,7,3) exactly 2 edges later, de_o rises same edge. hsync toggle appears on hsync_o 2 edges later. hcount=639 -> 0.
3. Frame-locked mode: change mode 0->1 at vcount=100 -> remainder of frame stays bars; next fs gives grid, with pixel (32,1) white and (33,1) black.
4. Char cells: mode 3 -> (0,0) green, (8,5) blue, (3,3) black, (8,16) green.
5. Scrolling: mode 5, SCROLL_STEP=2, run 320 frames -> offset 2,4,…,638,0 (wraps). Pixel x=0 in frame where offset=80 shows yellow. With freeze=1 for 3 frames -> offset constant while frame_cnt advances by 3.
6. Modes 6/7 and de gating: solid_rgb=8'b101_010_11 -> rgb=(5,2,3). Mode 7 -> 0. de=0 in any mode -> 0.
